// File: rtl/arith_pkg.sv
// Definitions shared across the arithmetic unit: the sequential FSM state encoding
// and the default datapath width also used by the Booth multiplier.
package arith_pkg;

  localparam int ARITH_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/twos_abs_neg.sv
// Conditional two's-complement negate: gives |x| when neg is the operand sign bit,
// or restores a sign when neg is the wanted result sign.
module twos_abs_neg #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] value,
  input  logic             neg,
  output logic [WIDTH-1:0] result
);

  assign result = neg ? (~value + 1'b1) : value;

endmodule

// File: rtl/seq_signed_divider.sv
// Sequential signed restoring divider, one quotient bit per clock, start/done handshake.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips CALC and finishes two cycles after start.
module seq_signed_divider
  import arith_pkg::*;
#(
  parameter int WIDTH = ARITH_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   partial;
  logic [WIDTH-1:0] quo_shift;
  logic [WIDTH-1:0] divisor_mag;
  logic             sign_q, sign_r, zero_div;
  logic [WIDTH-1:0] dividend_abs, divisor_abs;
  logic [WIDTH-1:0] quo_fix, rem_fix, rem_mag;
  logic [WIDTH+1:0] shifted, trial;

  assign busy = (state != ST_IDLE);

  twos_abs_neg #(.WIDTH(WIDTH)) u_abs_dividend (
    .value(dividend), .neg(dividend[WIDTH-1]), .result(dividend_abs));
  twos_abs_neg #(.WIDTH(WIDTH)) u_abs_divisor (
    .value(divisor), .neg(divisor[WIDTH-1]), .result(divisor_abs));
  twos_abs_neg #(.WIDTH(WIDTH)) u_fix_quotient (
    .value(quo_shift), .neg(sign_q), .result(quo_fix));
  twos_abs_neg #(.WIDTH(WIDTH)) u_fix_remainder (
    .value(rem_mag), .neg(sign_r), .result(rem_fix));

  // The extra top bit of the shifted pair makes the trial-subtract borrow visible.
  assign shifted = {partial, quo_shift[WIDTH-1]};
  assign trial   = shifted - {2'b00, divisor_mag};

`ifdef DIV_ZERO_FAST_EN
  // A skipped CALC leaves the dividend magnitude in the quotient shifter.
  assign rem_mag = zero_div ? quo_shift : partial[WIDTH-1:0];
`else
  assign rem_mag = partial[WIDTH-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
`ifdef DIV_ZERO_FAST_EN
          state_nxt = (divisor == '0) ? ST_FIX : ST_CALC;
`else
          state_nxt = ST_CALC;
`endif
        end
      end
      ST_CALC: if (count == CW'(1)) state_nxt = ST_FIX;
      ST_FIX:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      partial     <= '0;
      quo_shift   <= '0;
      divisor_mag <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      zero_div    <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values of the others.
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            sign_q      <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            sign_r      <= dividend[WIDTH-1];
            zero_div    <= (divisor == '0);
            quo_shift   <= dividend_abs;
            divisor_mag <= divisor_abs;
            partial     <= '0;
            count       <= CW'(WIDTH);
          end
        end
        ST_CALC: begin
          count     <= count - 1'b1;
          partial   <= trial[WIDTH+1] ? shifted[WIDTH:0] : trial[WIDTH:0];
          quo_shift <= {quo_shift[WIDTH-2:0], ~trial[WIDTH+1]};
        end
        ST_FIX: begin
          quotient    <= zero_div ? '1 : quo_fix;
          remainder   <= rem_fix;
          div_by_zero <= zero_div;
          done        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_signed_divider.sv
// Scoreboard bench for seq_signed_divider (WIDTH=4): directed cases, then all 256 operand pairs.
module tb_seq_signed_divider;

  localparam int W   = 4;
  localparam int LAT = W + 2;
`ifdef DIV_ZERO_FAST_EN
  localparam int LAT_DZ = 2;
`else
  localparam int LAT_DZ = LAT;
`endif

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           lat;
    int           acc;
    string        tag;
  } exp_t;

  exp_t sb[$];

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  seq_signed_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] q, input logic [W-1:0] r, input logic dz,
                              input int lat, input string tag);
    exp_t e;
    e.q = q; e.r = r; e.dz = dz; e.lat = lat; e.acc = 0; e.tag = tag;
    return e;
  endfunction

  // Reference: Verilog integer division/remainder, explicit zero-divisor results.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    int ai, bi;
    ai = int'($signed(a));
    bi = int'($signed(b));
    if (bi == 0) return mk('1, a, 1'b1, LAT_DZ, "sweep_dz");
    return mk(W'(ai / bi), W'(ai % bi), 1'b0, LAT, "sweep");
  endfunction

  // Called on a negedge with busy low; the following posedge accepts the operands.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
    exp_t x;
    x = e;
    x.acc = cyc + 1;
    start = 1'b1; dividend = a; divisor = b;
    sb.push_back(x);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("ready_timeout", 32'(busy), 32'd0);
  endtask

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
    wait_ready();
    issue(a, b, e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.tag, "_q"},   32'(quotient),    32'(e.q));
        check({e.tag, "_r"},   32'(remainder),   32'(e.r));
        check({e.tag, "_dz"},  32'(div_by_zero), 32'(e.dz));
        check({e.tag, "_lat"}, 32'(cyc - e.acc + 1), 32'(e.lat));
        check({e.tag, "_busy"}, 32'(busy), 32'd0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_q",    32'(quotient), 32'd0);
    check("rst_r",    32'(remainder), 32'd0);
    check("rst_dz",   32'(div_by_zero), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    op(4'd7, 4'd2, mk(4'd3, 4'd1, 1'b0, LAT, "p7_d2"));
    drain();
    op(4'h9, 4'd2, mk(4'hD, 4'hF, 1'b0, LAT, "m7_d2"));
    op(4'd7, 4'hE, mk(4'hD, 4'd1, 1'b0, LAT, "p7_dm2"));
    op(4'hA, 4'hD, mk(4'd2, 4'd0, 1'b0, LAT, "m6_dm3"));
    op(4'h8, 4'hF, mk(4'h8, 4'd0, 1'b0, LAT, "m8_dm1"));
    op(4'd0, 4'd5, mk(4'd0, 4'd0, 1'b0, LAT, "z_d5"));
    op(4'd5, 4'd0, mk(4'hF, 4'd5, 1'b1, LAT_DZ, "p5_d0"));
    drain();

    // Start pulse and operand change while busy must not disturb 7/2.
    op(4'd7, 4'd2, mk(4'd3, 4'd1, 1'b0, LAT, "busy_keep"));
    @(negedge clk);
    check("busy_high", 32'(busy), 32'd1);
    start = 1'b1; dividend = 4'd3; divisor = 4'd1;
    @(negedge clk);
    start = 1'b0;
    begin
      int n;
      n = 0;
      while (!done && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("done_seen", 32'(done), 32'd1);
    end
    issue(4'd6, 4'd4, mk(4'd1, 4'd2, 1'b0, LAT, "b2b_6_4"));
    drain();

    // Reset two edges into 7/2: everything clears and no done follows.
    wait_ready();
    start = 1'b1; dividend = 4'd7; divisor = 4'd2;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_q",    32'(quotient), 32'd0);
    check("abort_r",    32'(remainder), 32'd0);
    check("abort_dz",   32'(div_by_zero), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("abort_idle", 32'(busy), 32'd0);
    op(4'd6, 4'd3, mk(4'd2, 4'd0, 1'b0, LAT, "post_rst_6_3"));
    drain();

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        op(W'(a), W'(b), model(W'(a), W'(b)));
      end
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
